// File: rtl/irq_pkg.sv
// Shared types, defaults and sizing helper for the interrupt controller slice.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2,
        ST_DONE    = 2'd3
    } irq_state_t;

    localparam int WIN_LEN_DEF = 4;

    // Bits needed to index n items (never less than one).
    function automatic int id_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder with a valid flag.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = id_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] i_req,
    output logic [ID_W-1:0]    o_id,
    output logic               o_valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_id    = {ID_W{1'b0}};
        o_valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            o_id    = i_req[i] ? ID_W'(i) : o_id;
            o_valid = o_valid | i_req[i];
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-triggered, masked, fixed-priority interrupt requester for the CPU grant handshake.
// Optional build macro IRQ_TIMEOUT_EN aborts a request that is not granted in REQ_TIMEOUT cycles.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int ID_W        = id_width(NUM_SRC),
    parameter int WIN_LEN     = WIN_LEN_DEF,
    parameter int REQ_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] src_irq,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               eoi,
    input  logic               interrupt_grant,
    output logic               interrupt,
    output logic [ID_W-1:0]    irq_id,
    output logic               irq_active,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] mask,
    output logic               timeout_err
);

    localparam int              WC_W     = id_width(WIN_LEN);
    localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WIN_LEN - 1);

    if ((2 ** ID_W) < NUM_SRC || WIN_LEN < 2 || REQ_TIMEOUT < 1) begin : g_param_check
        $error("irq_ctrl: inconsistent parameters");
    end

    irq_state_t         r_state;
    irq_state_t         w_state_nxt;
    logic [NUM_SRC-1:0] r_src_q;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_req_vec;
    logic [ID_W-1:0]    r_irq_id;
    logic [ID_W-1:0]    w_enc_id;
    logic               w_enc_valid;
    logic               w_grant_acc;
    logic               w_exit;
    logic               w_timeout;
    logic [WC_W-1:0]    r_win_cnt;
    logic               r_eoi_seen;
    logic               r_interrupt;
    logic               r_irq_active;
    logic               w_interrupt_nxt;
    logic               w_active_nxt;

    assign w_edge      = src_irq & ~r_src_q;
    assign w_req_vec   = r_pending & r_mask;
    assign w_grant_acc = (r_state == ST_REQ) && interrupt_grant;
    assign w_clr       = w_grant_acc ? (NUM_SRC'(1) << r_irq_id) : {NUM_SRC{1'b0}};
    // A window may only close on its last cycle, so a late EOI waits for the next boundary.
    assign w_exit      = (r_state == ST_SERVICE) && (r_win_cnt == WIN_LAST) && (r_eoi_seen || eoi);

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .i_req   (w_req_vec),
        .o_id    (w_enc_id),
        .o_valid (w_enc_valid)
    );

`ifdef IRQ_TIMEOUT_EN
    localparam int              TO_W    = id_width(REQ_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(REQ_TIMEOUT - 1);

    logic [TO_W-1:0] r_req_cnt;
    logic            r_timeout_err;

    assign w_timeout   = (r_state == ST_REQ) && (r_req_cnt == TO_LAST);
    assign timeout_err = r_timeout_err;

    // Cycles spent in REQ and the sticky abort flag; a grant on the last cycle still wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_cnt     <= {TO_W{1'b0}};
            r_timeout_err <= 1'b0;
        end else begin
            r_req_cnt     <= (r_state == ST_REQ) ? (r_req_cnt + TO_W'(1)) : {TO_W{1'b0}};
            r_timeout_err <= r_timeout_err | (w_timeout & ~interrupt_grant);
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register plus the registered request outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_interrupt  <= 1'b0;
            r_irq_active <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_interrupt  <= w_interrupt_nxt;
            r_irq_active <= w_active_nxt;
        end
    end

    // Next-state decision.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_enc_valid) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (interrupt_grant) begin
                    w_state_nxt = ST_SERVICE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (w_exit) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SERVICE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        w_interrupt_nxt = 1'b0;
        w_active_nxt    = 1'b0;
        case (w_state_nxt)
            ST_REQ:     w_interrupt_nxt = 1'b1;
            ST_SERVICE: begin
                w_interrupt_nxt = 1'b1;
                w_active_nxt    = 1'b1;
            end
            default: begin
                w_interrupt_nxt = 1'b0;
                w_active_nxt    = 1'b0;
            end
        endcase
    end

    // Source sampling, pending/mask registers, latched ID and window bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src_q    <= {NUM_SRC{1'b0}};
            r_pending  <= {NUM_SRC{1'b0}};
            r_mask     <= {NUM_SRC{1'b1}};
            r_irq_id   <= {ID_W{1'b0}};
            r_win_cnt  <= {WC_W{1'b0}};
            r_eoi_seen <= 1'b0;
        end else begin
            r_src_q   <= src_irq;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            r_mask    <= mask_we ? mask_wdata : r_mask;
            r_irq_id  <= ((r_state == ST_IDLE) && w_enc_valid) ? w_enc_id : r_irq_id;
            if (w_grant_acc) begin
                r_win_cnt <= WC_W'(1);
            end else if (r_state == ST_SERVICE) begin
                r_win_cnt <= (r_win_cnt == WIN_LAST) ? {WC_W{1'b0}} : (r_win_cnt + WC_W'(1));
            end else begin
                r_win_cnt <= {WC_W{1'b0}};
            end
            if (r_state == ST_SERVICE) begin
                r_eoi_seen <= w_exit ? 1'b0 : (r_eoi_seen | eoi);
            end else begin
                r_eoi_seen <= 1'b0;
            end
        end
    end

    assign interrupt  = r_interrupt;
    assign irq_id     = r_irq_id;
    assign irq_active = r_irq_active;
    assign pending    = r_pending;
    assign mask       = r_mask;

endmodule
